// File: rtl/fpro_bus_arbiter.sv
// fpro_bus_arbiter: round-robin arbiter sharing the FPro MMIO bus between two req/ack masters.
// Each transaction runs IDLE (grant) -> ISSUE (single strobe cycle) -> DONE (ack pulse).
module fpro_bus_arbiter #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic [DATA_W-1:0] m0_rd_data,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              m1_ack,
  output logic              busy,
  output logic              fp_mmio_cs,
  output logic              fp_wr,
  output logic              fp_rd,
  output logic [ADDR_W-1:0] fp_addr,
  output logic [DATA_W-1:0] fp_wr_data,
  input  logic [DATA_W-1:0] fp_rd_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       sel;
  logic       wr_lat;
  logic       last_grant;
  logic       win;
  logic       grant;

  // Winner: on a tie the master that was not granted last goes first.
  always_comb begin
    win = 1'b0;
    if (m0_req && m1_req) begin
      win = ~last_grant;
    end else if (m1_req) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
  end

  assign grant = (state == IDLE) && (m0_req || m1_req);

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Transaction attributes are captured at grant, so a late req drop cannot abort it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel        <= 1'b0;
      wr_lat     <= 1'b0;
      fp_addr    <= '0;
      fp_wr_data <= '0;
    end else if (grant) begin
      sel        <= win;
      wr_lat     <= win ? m1_wr : m0_wr;
      fp_addr    <= win ? m1_addr : m0_addr;
      fp_wr_data <= win ? m1_wr_data : m0_wr_data;
    end
  end

  // Round-robin history, reset to 1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (state == ISSUE) begin
      last_grant <= sel;
    end
  end

  // Read data is captured only for the selected master on a read strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_rd_data <= '0;
      m1_rd_data <= '0;
    end else if ((state == ISSUE) && !wr_lat) begin
      if (sel) begin
        m1_rd_data <= fp_rd_data;
      end else begin
        m0_rd_data <= fp_rd_data;
      end
    end
  end

  // Strobes and acks decode only registered state, so they are glitch-free.
  assign fp_mmio_cs = (state == ISSUE);
  assign fp_wr      = (state == ISSUE) && wr_lat;
  assign fp_rd      = (state == ISSUE) && !wr_lat;
  assign m0_ack     = (state == DONE) && !sel;
  assign m1_ack     = (state == DONE) && sel;
  assign busy       = (state != IDLE);

endmodule
